// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/shift/add/sub ops plus iterative
// shift-add multiply and restoring divide/modulo with an execute/busy/done handshake.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [3:0]       control,
    input  logic             execute,
    output logic [WIDTH-1:0] out,
    output logic             zf,
    output logic             cf,
    output logic             busy,
    output logic             done
);

    localparam logic [3:0] OP_NAND = 4'b0000;
    localparam logic [3:0] OP_AND  = 4'b0001;
    localparam logic [3:0] OP_XOR  = 4'b0010;
    localparam logic [3:0] OP_SHR  = 4'b0011;
    localparam logic [3:0] OP_PASS = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_ADD  = 4'b0110;
    localparam logic [3:0] OP_SUB  = 4'b0111;
    localparam logic [3:0] OP_SHL  = 4'b1000;
    localparam logic [3:0] OP_MUL  = 4'b1001;
    localparam logic [3:0] OP_DIV  = 4'b1010;
    localparam logic [3:0] OP_MOD  = 4'b1011;

    localparam int             CW      = $clog2(WIDTH + 1);
    localparam logic [WIDTH:0] WIDTH_V = (WIDTH + 1)'(WIDTH);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t state, state_next;

    logic [CW-1:0]        count;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   product;
    logic [WIDTH-1:0]     rem;
    logic [WIDTH-1:0]     quot;
    logic [WIDTH-1:0]     divisor;
    logic                 is_mod;

    logic                 last;
    logic [2*WIDTH-1:0]   prod_next;
    logic [WIDTH+1:0]     div_shift;
    logic [WIDTH+1:0]     div_diff;
    logic                 div_ok;
    logic [WIDTH-1:0]     rem_next;
    logic [WIDTH-1:0]     quot_next;
    logic [WIDTH-1:0]     div_res;
    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       diff;
    logic [SHW-1:0]       shamt;
    logic                 shift_big;

    logic [WIDTH-1:0]     op_res;
    logic                 op_cf;
    logic                 op_zf;
    logic                 op_multi;

    assign busy  = (state != IDLE);
    assign last  = (count == CW'(WIDTH - 1));

    assign sum       = {1'b0, in_a} + {1'b0, in_b};
    assign diff      = {1'b0, in_a} - {1'b0, in_b};
    assign shamt     = in_b[SHW-1:0];
    assign shift_big = ({1'b0, in_b} >= WIDTH_V);

    // One multiply step: add the shifted multiplicand when the current multiplier bit is set.
    assign prod_next = product + (mplier[0] ? mcand : '0);

    // One restoring-divide step: the top bit of diff is the borrow of the trial subtraction.
    assign div_shift = {1'b0, rem, quot[WIDTH-1]};
    assign div_diff  = div_shift - {2'b00, divisor};
    assign div_ok    = ~div_diff[WIDTH+1];
    assign rem_next  = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    assign quot_next = {quot[WIDTH-2:0], div_ok};
    assign div_res   = is_mod ? rem_next : quot_next;

    always_comb begin
        op_res   = out;
        op_cf    = cf;
        op_zf    = zf;
        op_multi = 1'b0;
        case (control)
            OP_NAND: op_res = ~(in_a & in_b);
            OP_AND:  op_res = in_a & in_b;
            OP_XOR:  op_res = in_a ^ in_b;
            OP_SHR:  op_res = shift_big ? '0 : (in_a >> shamt);
            OP_PASS: op_res = in_b;
            OP_OR:   op_res = in_a | in_b;
            OP_ADD: begin
                op_res = sum[WIDTH-1:0];
                op_cf  = sum[WIDTH];
                op_zf  = (sum[WIDTH-1:0] == '0);
            end
            OP_SUB: begin
                op_res = diff[WIDTH-1:0];
                op_cf  = diff[WIDTH];
                op_zf  = (diff[WIDTH-1:0] == '0);
            end
            OP_SHL:  op_res = shift_big ? '0 : (in_a << shamt);
            OP_MUL:  op_multi = 1'b1;
            OP_DIV, OP_MOD: begin
                // Division by zero finishes immediately and never enters the DIV state.
                if (in_b == '0) begin
                    op_res = (control == OP_DIV) ? '1 : in_a;
                    op_cf  = 1'b1;
                    op_zf  = 1'b0;
                end else begin
                    op_multi = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (execute && op_multi)
                    state_next = (control == OP_MUL) ? MUL : DIV;
            end
            MUL, DIV: if (last) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out     <= '0;
            zf      <= 1'b0;
            cf      <= 1'b0;
            done    <= 1'b0;
            count   <= '0;
            mcand   <= '0;
            mplier  <= '0;
            product <= '0;
            rem     <= '0;
            quot    <= '0;
            divisor <= '0;
            is_mod  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (execute) begin
                        out     <= op_res;
                        cf      <= op_cf;
                        zf      <= op_zf;
                        done    <= ~op_multi;
                        count   <= '0;
                        product <= '0;
                        mcand   <= {{WIDTH{1'b0}}, in_a};
                        mplier  <= in_b;
                        rem     <= '0;
                        quot    <= in_a;
                        divisor <= in_b;
                        is_mod  <= (control == OP_MOD);
                    end
                end
                MUL: begin
                    product <= prod_next;
                    mcand   <= mcand << 1;
                    mplier  <= mplier >> 1;
                    count   <= count + 1'b1;
                    if (last) begin
                        out  <= prod_next[WIDTH-1:0];
                        cf   <= |prod_next[2*WIDTH-1:WIDTH];
                        zf   <= (prod_next[WIDTH-1:0] == '0);
                        done <= 1'b1;
                    end
                end
                DIV: begin
                    rem   <= rem_next;
                    quot  <= quot_next;
                    count <= count + 1'b1;
                    if (last) begin
                        out  <= div_res;
                        cf   <= 1'b0;
                        zf   <= (div_res == '0);
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=8): each task drives one
// scenario and compares outputs against hand-computed values.
module tb_alu_seq;

    localparam int WIDTH = 8;

    localparam logic [3:0] OP_AND  = 4'b0001;
    localparam logic [3:0] OP_SHR  = 4'b0011;
    localparam logic [3:0] OP_PASS = 4'b0100;
    localparam logic [3:0] OP_ADD  = 4'b0110;
    localparam logic [3:0] OP_SUB  = 4'b0111;
    localparam logic [3:0] OP_SHL  = 4'b1000;
    localparam logic [3:0] OP_MUL  = 4'b1001;
    localparam logic [3:0] OP_DIV  = 4'b1010;
    localparam logic [3:0] OP_MOD  = 4'b1011;
    localparam logic [3:0] OP_NOP  = 4'b1101;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic [3:0]       control = '0;
    logic             execute = 1'b0;
    logic [WIDTH-1:0] out;
    logic             zf, cf, busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    alu_seq #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .in_a(in_a), .in_b(in_b), .control(control),
        .execute(execute), .out(out), .zf(zf), .cf(cf), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Present one request at the falling edge; return 1ns after the accepting rising edge.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        @(negedge clk);
        in_a = a; in_b = b; control = op; execute = 1'b1;
        @(posedge clk); #1;
        execute = 1'b0;
    endtask

    // Count edges until done rises (bounded); optionally pulse an ADD request while busy.
    task automatic wait_done(input bit poke, output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < 40) begin
            @(posedge clk); #1;
            cycles++;
            if (poke) begin
                in_a = 8'h01; in_b = 8'h01; control = OP_ADD;
                execute = (cycles >= 1 && cycles <= 4);
            end
        end
        execute = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        n_checks++; if ({out, zf, cf, busy, done} !== 12'h000) begin n_fail++; $display("[TB] FAIL reset_init: got out=%h zf=%b cf=%b busy=%b done=%b expected all 0", out, zf, cf, busy, done); end
        @(negedge clk); rst = 1'b0;
        issue(8'hF0, 8'h20, OP_ADD);
        n_checks++; if (out !== 8'h10) begin n_fail++; $display("[TB] FAIL add_out: got %h expected 10", out); end
        n_checks++; if ({cf, zf} !== 2'b10) begin n_fail++; $display("[TB] FAIL add_flags: got cf=%b zf=%b expected cf=1 zf=0", cf, zf); end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("[TB] FAIL add_done: got %b expected 1", done); end
        @(posedge clk); #1;
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL add_done_pulse: got %b expected 0", done); end
        @(negedge clk); #2 rst = 1'b1; #1;
        n_checks++; if ({out, zf, cf, busy, done} !== 12'h000) begin n_fail++; $display("[TB] FAIL reset_async: got out=%h zf=%b cf=%b busy=%b done=%b expected all 0", out, zf, cf, busy, done); end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_sub;
        issue(8'd5, 8'd7, OP_SUB);
        n_checks++; if (out !== 8'hFE) begin n_fail++; $display("[TB] FAIL sub_neg_out: got %h expected fe", out); end
        n_checks++; if ({cf, zf} !== 2'b10) begin n_fail++; $display("[TB] FAIL sub_neg_flags: got cf=%b zf=%b expected cf=1 zf=0", cf, zf); end
        issue(8'd5, 8'd5, OP_SUB);
        n_checks++; if (out !== 8'h00) begin n_fail++; $display("[TB] FAIL sub_eq_out: got %h expected 00", out); end
        n_checks++; if ({cf, zf} !== 2'b01) begin n_fail++; $display("[TB] FAIL sub_eq_flags: got cf=%b zf=%b expected cf=0 zf=1", cf, zf); end
        issue(8'h00, 8'h00, OP_AND);
        n_checks++; if ({out, cf, zf} !== 10'b00000000_01) begin n_fail++; $display("[TB] FAIL and_hold: got out=%h cf=%b zf=%b expected 00 cf=0 zf=1", out, cf, zf); end
    endtask

    task automatic test_mul;
        int cyc;
        issue(8'd13, 8'd11, OP_MUL);
        n_checks++; if ({busy, done} !== 2'b10) begin n_fail++; $display("[TB] FAIL mul_start: got busy=%b done=%b expected busy=1 done=0", busy, done); end
        wait_done(1'b0, cyc);
        n_checks++; if (cyc !== 8) begin n_fail++; $display("[TB] FAIL mul_latency: got %0d expected 8", cyc); end
        n_checks++; if ({out, cf, zf, busy} !== {8'h8F, 3'b000}) begin n_fail++; $display("[TB] FAIL mul_13x11: got out=%h cf=%b zf=%b busy=%b expected 8f 0 0 0", out, cf, zf, busy); end
        issue(8'd20, 8'd20, OP_MUL);
        wait_done(1'b1, cyc);
        n_checks++; if (cyc !== 8) begin n_fail++; $display("[TB] FAIL mul_poke_latency: got %0d expected 8", cyc); end
        n_checks++; if ({out, cf, zf} !== {8'h90, 2'b10}) begin n_fail++; $display("[TB] FAIL mul_20x20: got out=%h cf=%b zf=%b expected 90 1 0", out, cf, zf); end
        @(posedge clk); #1;
        n_checks++; if ({out, busy, done} !== {8'h90, 2'b00}) begin n_fail++; $display("[TB] FAIL mul_no_queue: got out=%h busy=%b done=%b expected 90 0 0", out, busy, done); end
    endtask

    task automatic test_div;
        int cyc;
        issue(8'd200, 8'd7, OP_DIV);
        wait_done(1'b0, cyc);
        n_checks++; if (cyc !== 8) begin n_fail++; $display("[TB] FAIL div_latency: got %0d expected 8", cyc); end
        n_checks++; if ({out, cf, zf} !== {8'd28, 2'b00}) begin n_fail++; $display("[TB] FAIL div_200_7: got out=%0d cf=%b zf=%b expected 28 0 0", out, cf, zf); end
        issue(8'd200, 8'd7, OP_MOD);
        wait_done(1'b0, cyc);
        n_checks++; if ({out, cf, zf} !== {8'd4, 2'b00}) begin n_fail++; $display("[TB] FAIL mod_200_7: got out=%0d cf=%b zf=%b expected 4 0 0", out, cf, zf); end
        issue(8'd9, 8'd0, OP_DIV);
        n_checks++; if ({out, cf, zf, busy, done} !== {8'hFF, 4'b1001}) begin n_fail++; $display("[TB] FAIL div_zero: got out=%h cf=%b zf=%b busy=%b done=%b expected ff 1 0 0 1", out, cf, zf, busy, done); end
        issue(8'd9, 8'd0, OP_MOD);
        n_checks++; if ({out, cf, zf, busy} !== {8'd9, 3'b100}) begin n_fail++; $display("[TB] FAIL mod_zero: got out=%h cf=%b zf=%b busy=%b expected 09 1 0 0", out, cf, zf, busy); end
    endtask

    task automatic test_shift;
        issue(8'h80, 8'd3, OP_SHR);
        n_checks++; if (out !== 8'h10) begin n_fail++; $display("[TB] FAIL shr: got %h expected 10", out); end
        issue(8'h01, 8'd9, OP_SHL);
        n_checks++; if ({out, cf, zf} !== {8'h00, 2'b10}) begin n_fail++; $display("[TB] FAIL shl_big: got out=%h cf=%b zf=%b expected 00 1 0", out, cf, zf); end
        issue(8'h00, 8'h5A, OP_PASS);
        n_checks++; if ({out, cf, zf} !== {8'h5A, 2'b10}) begin n_fail++; $display("[TB] FAIL pass: got out=%h cf=%b zf=%b expected 5a 1 0", out, cf, zf); end
        issue(8'hFF, 8'hFF, OP_NOP);
        n_checks++; if ({out, done} !== {8'h5A, 1'b1}) begin n_fail++; $display("[TB] FAIL nop: got out=%h done=%b expected 5a 1", out, done); end
    endtask

    task automatic test_back_to_back;
        int cyc;
        issue(8'd3, 8'd4, OP_MUL);
        wait_done(1'b0, cyc);
        n_checks++; if (out !== 8'd12) begin n_fail++; $display("[TB] FAIL b2b_mul: got %0d expected 12", out); end
        issue(8'd1, 8'd2, OP_ADD);
        n_checks++; if ({out, done, busy} !== {8'd3, 2'b10}) begin n_fail++; $display("[TB] FAIL b2b_add: got out=%0d done=%b busy=%b expected 3 1 0", out, done, busy); end
    endtask

    task automatic test_reset_mid_mul;
        int cyc;
        bit seen_done;
        issue(8'd13, 8'd11, OP_MUL);
        repeat (3) @(posedge clk);
        @(negedge clk); #1 rst = 1'b1; #1;
        n_checks++; if ({out, busy, done, cf} !== {8'h00, 3'b000}) begin n_fail++; $display("[TB] FAIL mid_reset: got out=%h busy=%b done=%b cf=%b expected 00 0 0 0", out, busy, done, cf); end
        @(negedge clk); rst = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
        end
        n_checks++; if (seen_done !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_reset_abort: got done/busy activity=%b expected 0", seen_done); end
        issue(8'd3, 8'd3, OP_MUL);
        wait_done(1'b0, cyc);
        n_checks++; if ({out, cf, zf} !== {8'd9, 2'b00} || cyc !== 8) begin n_fail++; $display("[TB] FAIL mul_after_reset: got out=%0d cf=%b zf=%b cycles=%0d expected 9 0 0 8", out, cf, zf, cyc); end
    endtask

    initial begin
        test_reset();
        test_sub();
        test_mul();
        test_div();
        test_shift();
        test_back_to_back();
        test_reset_mid_mul();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
